// File: rtl/vrf_read_arbiter.sv
// vrf_read_arbiter: round-robin, burst-granular arbitration of the single
// vector-register-file read port between NUM_REQ operand sequencers, with a
// fixed-latency tag pipeline that routes returned data to the issuing requester.
module vrf_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 64,
  parameter int RD_LATENCY = 2
) (
  input  logic                            clk_i,
  input  logic                            arst_ni,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0]              req_last_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic                            rf_ready_i,
  output logic                            rf_en_o,
  output logic [ADDR_W-1:0]               rf_addr_o,
  input  logic [DATA_W-1:0]               rf_data_i,
  output logic [DATA_W-1:0]               rsp_data_o,
  output logic [NUM_REQ-1:0]              rsp_valid_o
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e                          state_q, state_d;
  logic [ID_W-1:0]                 ptr_q, ptr_d;
  logic [ID_W-1:0]                 owner_q, owner_d;
  logic [RD_LATENCY-1:0]           tag_vld_q;
  logic [RD_LATENCY-1:0][ID_W-1:0] tag_id_q;

  logic                            win_found;
  logic [ID_W-1:0]                 win_id;
  logic [ID_W-1:0]                 cand;
  logic [ID_W-1:0]                 sel_id;
  logic                            beat;
  logic [NUM_REQ-1:0]              ready;

  // Increment a requester index with wrap at NUM_REQ (handles non-power-of-2 counts).
  function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

  // Find the first valid requester at or after the round-robin pointer, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
      cand = inc_id(cand);
    end
  end

  // Next-state, pointer/owner update and grant generation; a burst holds the port until its last beat.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    ready   = '0;
    beat    = 1'b0;
    sel_id  = win_id;
    case (state_q)
      IDLE: begin
        if (win_found && rf_ready_i) begin
          ready[win_id] = 1'b1;
          beat          = 1'b1;
          if (req_last_i[win_id]) begin
            ptr_d = inc_id(win_id);
          end else begin
            state_d = LOCKED;
            owner_d = win_id;
          end
        end
      end
      LOCKED: begin
        // The owner keeps the port even while its valid is low; nobody else gets in.
        sel_id         = owner_q;
        ready[owner_q] = rf_ready_i;
        if (rf_ready_i && req_valid_i[owner_q]) begin
          beat = 1'b1;
          if (req_last_i[owner_q]) begin
            state_d = IDLE;
            ptr_d   = inc_id(owner_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Tag pipeline: shifts every cycle so a response lines up exactly RD_LATENCY cycles after its beat.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      for (int s = RD_LATENCY - 1; s > 0; s--) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
      tag_vld_q[0] <= beat;
      tag_id_q[0]  <= sel_id;
    end
  end

  // Outputs; everything combinational is held at zero while reset is asserted.
  always_comb begin
    req_ready_o = arst_ni ? ready : '0;
    rf_en_o     = arst_ni & beat;
    rf_addr_o   = (arst_ni && beat) ? req_addr_i[sel_id] : '0;
    rsp_data_o  = arst_ni ? rf_data_i : '0;
    rsp_valid_o = '0;
    if (arst_ni && tag_vld_q[RD_LATENCY-1]) begin
      rsp_valid_o[tag_id_q[RD_LATENCY-1]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_vrf_read_arbiter.sv
// Directed, table-driven bench for vrf_read_arbiter (NUM_REQ=4, RD_LATENCY=2).
module tb_vrf_read_arbiter;

  localparam int NR = 4;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int RL = 2;

  logic                   clk_i = 1'b0;
  logic                   arst_ni;
  logic [NR-1:0][AW-1:0]  req_addr_i;
  logic [NR-1:0]          req_last_i;
  logic [NR-1:0]          req_valid_i;
  logic [NR-1:0]          req_ready_o;
  logic                   rf_ready_i;
  logic                   rf_en_o;
  logic [AW-1:0]          rf_addr_o;
  logic [DW-1:0]          rf_data_i;
  logic [DW-1:0]          rsp_data_o;
  logic [NR-1:0]          rsp_valid_o;

  always #5 clk_i = ~clk_i;

  vrf_read_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RL)
  ) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .req_addr_i(req_addr_i), .req_last_i(req_last_i), .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o), .rf_ready_i(rf_ready_i),
    .rf_en_o(rf_en_o), .rf_addr_o(rf_addr_o), .rf_data_i(rf_data_i),
    .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o)
  );

  // Register-file model: data is a fixed function of the address, returned RL cycles later.
  function automatic logic [DW-1:0] rfval(input logic [AW-1:0] a);
    return 64'hC0DE_0000_0000_0000 + (64'(a) * 64'h0000_0101_0001_0001);
  endfunction

  logic [AW-1:0] rfa_p1 = '0, rfa_p2 = '0;
  always @(posedge clk_i) begin
    rfa_p1 <= rf_addr_o;
    rfa_p2 <= rfa_p1;
  end
  assign rf_data_i = rfval(rfa_p2);

  typedef struct {
    bit                    rb;    // reset before this vector
    logic [NR-1:0]         v;
    logic [NR-1:0]         l;
    logic [NR-1:0][AW-1:0] a;
    logic                  rdy;
    logic [NR-1:0]         er;    // expected req_ready_o
    logic [NR-1:0]         ersp;  // expected rsp_valid_o
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [AW-1:0] ed1 = '0, ed2 = '0;

  function automatic vec_t mk(input bit rb, input logic [3:0] v, input logic [3:0] l,
                              input int a0, input int a1, input int a2, input int a3,
                              input logic rdy, input logic [3:0] er, input logic [3:0] ersp);
    vec_t t;
    t.rb = rb; t.v = v; t.l = l; t.rdy = rdy; t.er = er; t.ersp = ersp;
    t.a[0] = AW'(a0); t.a[1] = AW'(a1); t.a[2] = AW'(a2); t.a[3] = AW'(a3);
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t t);
    req_valid_i = t.v;
    req_last_i  = t.l;
    req_addr_i  = t.a;
    rf_ready_i  = t.rdy;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ready"}, 64'(req_ready_o), 64'd0);
    chk({tag, " en"}, 64'(rf_en_o), 64'd0);
    chk({tag, " addr"}, 64'(rf_addr_o), 64'd0);
    chk({tag, " rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    chk({tag, " rsp_data"}, rsp_data_o, 64'd0);
  endtask

  task automatic do_reset();
    req_valid_i = '0; req_last_i = '0; req_addr_i = '0; rf_ready_i = 1'b1;
    arst_ni = 1'b0;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    arst_ni = 1'b1;
  endtask

  // Apply one vector for one cycle and compare at the falling edge.
  task automatic run_vec(input vec_t t, input int idx);
    logic [NR-1:0] acc;
    logic          een;
    logic [AW-1:0] ea;
    @(posedge clk_i);
    #1;
    drive(t);
    @(negedge clk_i);
    acc = t.er & t.v;
    een = |acc;
    ea  = '0;
    for (int i = 0; i < NR; i++) if (acc[i]) ea = t.a[i];
    chk($sformatf("v%0d ready", idx), 64'(req_ready_o), 64'(t.er));
    chk($sformatf("v%0d en", idx), 64'(rf_en_o), 64'(een));
    chk($sformatf("v%0d addr", idx), 64'(rf_addr_o), 64'(ea));
    chk($sformatf("v%0d rsp_valid", idx), 64'(rsp_valid_o), 64'(t.ersp));
    if (t.ersp != '0) chk($sformatf("v%0d rsp_data", idx), rsp_data_o, rfval(ed2));
    chk($sformatf("v%0d rsp_onehot0", idx), 64'($onehot0(rsp_valid_o)), 64'd1);
    chk($sformatf("v%0d ready_onehot0", idx), 64'($onehot0(req_ready_o)), 64'd1);
    chk($sformatf("v%0d en_needs_rdy", idx), 64'(!rf_en_o || rf_ready_i), 64'd1);
    ed2 = ed1;
    ed1 = ea;
  endtask

  initial begin
    arst_ni = 1'b0;
    req_valid_i = '0; req_last_i = '0; req_addr_i = '0; rf_ready_i = 1'b0;

    // Single requester, 4-beat burst.
    tbl.push_back(mk(1, 4'b0001, 4'b0000,  3, 0, 0, 0, 1, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b0001, 4'b0000,  7, 0, 0, 0, 1, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b0001, 4'b0000,  9, 0, 0, 0, 1, 4'b0001, 4'b0001));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 10, 0, 0, 0, 1, 4'b0001, 4'b0001));
    tbl.push_back(mk(0, 4'b0000, 4'b0000,  0, 0, 0, 0, 1, 4'b0000, 4'b0001));
    tbl.push_back(mk(0, 4'b0000, 4'b0000,  0, 0, 0, 0, 1, 4'b0000, 4'b0001));
    tbl.push_back(mk(0, 4'b0000, 4'b0000,  0, 0, 0, 0, 1, 4'b0000, 4'b0000));
    // Contention and lock, then pointer at 2 favours req2 over a new req0 burst.
    tbl.push_back(mk(1, 4'b0011, 4'b0000,  1, 11,  0, 0, 1, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b0011, 4'b0000,  2, 11,  0, 0, 1, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b0011, 4'b0000,  3, 11,  0, 0, 1, 4'b0001, 4'b0001));
    tbl.push_back(mk(0, 4'b0011, 4'b0001,  4, 11,  0, 0, 1, 4'b0001, 4'b0001));
    tbl.push_back(mk(0, 4'b0010, 4'b0000,  0, 11,  0, 0, 1, 4'b0010, 4'b0001));
    tbl.push_back(mk(0, 4'b0010, 4'b0000,  0, 12,  0, 0, 1, 4'b0010, 4'b0001));
    tbl.push_back(mk(0, 4'b0010, 4'b0000,  0, 13,  0, 0, 1, 4'b0010, 4'b0010));
    tbl.push_back(mk(0, 4'b0010, 4'b0010,  0, 14,  0, 0, 1, 4'b0010, 4'b0010));
    tbl.push_back(mk(0, 4'b0101, 4'b0101,  5,  0, 20, 0, 1, 4'b0100, 4'b0010));
    tbl.push_back(mk(0, 4'b0001, 4'b0001,  5,  0,  0, 0, 1, 4'b0001, 4'b0010));
    tbl.push_back(mk(0, 4'b0000, 4'b0000,  0,  0,  0, 0, 1, 4'b0000, 4'b0100));
    tbl.push_back(mk(0, 4'b0000, 4'b0000,  0,  0,  0, 0, 1, 4'b0000, 4'b0001));
    // Round-robin wrap with single-beat bursts from everyone.
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 1, 2, 3, 4, 1, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 2, 3, 4, 1, 4'b0010, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 2, 3, 4, 1, 4'b0100, 4'b0001));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 2, 3, 4, 1, 4'b1000, 4'b0010));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 2, 3, 4, 1, 4'b0001, 4'b0100));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 2, 3, 4, 1, 4'b0010, 4'b1000));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 4'b0001));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 4'b0010));
    // Port stall mid-burst of req2 while req1 waits (pointer is 2 here).
    tbl.push_back(mk(0, 4'b0110, 4'b0010, 0, 15, 21, 0, 1, 4'b0100, 4'b0000));
    tbl.push_back(mk(0, 4'b0110, 4'b0010, 0, 15, 22, 0, 1, 4'b0100, 4'b0000));
    tbl.push_back(mk(0, 4'b0110, 4'b0010, 0, 15, 23, 0, 0, 4'b0000, 4'b0100));
    tbl.push_back(mk(0, 4'b0110, 4'b0010, 0, 15, 23, 0, 0, 4'b0000, 4'b0100));
    tbl.push_back(mk(0, 4'b0110, 4'b0010, 0, 15, 23, 0, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 4'b0110, 4'b0010, 0, 15, 23, 0, 1, 4'b0100, 4'b0000));
    tbl.push_back(mk(0, 4'b0110, 4'b0110, 0, 15, 24, 0, 1, 4'b0100, 4'b0000));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, 15,  0, 0, 1, 4'b0010, 4'b0100));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0,  0,  0, 0, 1, 4'b0000, 4'b0100));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0,  0,  0, 0, 1, 4'b0000, 4'b0010));
    // Owner bubble: req1 owns the port and drops valid; req3 must wait.
    tbl.push_back(mk(1, 4'b1010, 4'b1000, 0, 6, 0, 30, 1, 4'b0010, 4'b0000));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 0, 6, 0, 30, 1, 4'b0010, 4'b0000));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 0, 6, 0, 30, 1, 4'b0010, 4'b0010));
    tbl.push_back(mk(0, 4'b1010, 4'b1000, 0, 7, 0, 30, 1, 4'b0010, 4'b0000));
    tbl.push_back(mk(0, 4'b1010, 4'b1010, 0, 8, 0, 30, 1, 4'b0010, 4'b0000));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 0, 0, 0, 30, 1, 4'b1000, 4'b0010));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0,  0, 1, 4'b0000, 4'b0010));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0,  0, 1, 4'b0000, 4'b1000));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rb) do_reset();
      run_vec(tbl[i], i);
    end

    // Reset with a lock held and reads in flight.
    do_reset();
    run_vec(mk(0, 4'b0010, 4'b0010, 0, 9,  0, 0, 1, 4'b0010, 4'b0000), 100);
    run_vec(mk(0, 4'b0100, 4'b0000, 0, 0, 12, 0, 1, 4'b0100, 4'b0000), 101);
    @(posedge clk_i);
    #1;
    drive(mk(0, 4'b1111, 4'b1111, 1, 2, 3, 4, 1, 4'b0000, 4'b0000));
    arst_ni = 1'b0;
    #1;
    chk_zero("inflight_rst");
    repeat (2) @(posedge clk_i);
    req_valid_i = '0;
    @(negedge clk_i);
    arst_ni = 1'b1;
    run_vec(mk(0, 4'b1111, 4'b1111, 1, 2, 3, 4, 1, 4'b0001, 4'b0000), 102);
    run_vec(mk(0, 4'b1111, 4'b1111, 1, 2, 3, 4, 1, 4'b0010, 4'b0000), 103);
    run_vec(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 4'b0001), 104);
    run_vec(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 4'b0010), 105);
    run_vec(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 4'b0000, 4'b0000), 106);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
